ql_fifo_sync: RTL

- Parametrised single-clock, register-based FIFO for soft logic. Generalises the FIFO mode of the hard RAM block to any width and power-of-two depth.
- Provides the same four-flag interface as the hard block (empty, almost-empty, almost-full, full), with programmable thresholds, synchronous flush and sticky error flags.
- Used where a hard RAM is unavailable or too large, e.g. IO-side buffering between IN_REG/OUT_REG paths and fabric logic.

---
 rtl/ql_fifo_pkg.sv | 29 ++
 rtl/ql_fifo_ctrl.sv | 105 ++++++++++
 rtl/ql_fifo_sync.sv | 73 +++++++
 3 files changed

// File: rtl/ql_fifo_pkg.sv
// Shared definitions for the soft-logic synchronous FIFO: flag bit positions
// and the occupancy-to-flag mapping used by the controller.
package ql_fifo_pkg;

    localparam int FF_EMPTY  = 0;
    localparam int FF_AEMPTY = 1;
    localparam int FF_AFULL  = 2;
    localparam int FF_FULL   = 3;

    // Flags after reset or flush: empty and almost-empty, independent of thresholds.
    localparam logic [3:0] FF_RESET = 4'b0011;

    // Nine bits covers every occupancy and threshold up to DEPTH=256.
    function automatic logic [3:0] calc_flags(
        input logic [8:0] cnt,
        input logic [8:0] ae_th,
        input logic [8:0] af_th,
        input logic [8:0] depth
    );
        logic [3:0] f;
        f            = 4'b0000;
        f[FF_EMPTY]  = (cnt == 9'd0);
        f[FF_AEMPTY] = (cnt <= ae_th);
        f[FF_AFULL]  = (cnt >= af_th);
        f[FF_FULL]   = (cnt == depth);
        return f;
    endfunction

endpackage

// File: rtl/ql_fifo_ctrl.sv
// Pointer, occupancy, flag and sticky-error bookkeeping for ql_fifo_sync.
// Acceptance strobes go to the top level, which owns storage and rdata.
module ql_fifo_ctrl
    import ql_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wen,
    input  logic          ren,
    input  logic          fflush,
    input  logic [AW:0]   upae,
    input  logic [AW:0]   upaf,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic          wr_acc,
    output logic          rd_acc,
    output logic [AW:0]   count,
    output logic [3:0]    fflags,
    output logic          ovf,
    output logic          udf,
    output logic          rvalid
);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [3:0]    r_flags;
    logic          r_ovf;
    logic          r_udf;
    logic          r_rvalid;

    logic          w_full;
    logic          w_empty;
    logic          w_rd_acc;
    logic          w_wr_acc;
    logic [AW:0]   w_cnt_nxt;
    logic [3:0]    w_flags_nxt;

    assign w_full   = r_flags[FF_FULL];
    assign w_empty  = r_flags[FF_EMPTY];
    assign w_rd_acc = ren && !w_empty && !fflush;
    // Writing into a full FIFO is legal only when a read frees a slot this cycle.
    assign w_wr_acc = wen && (!w_full || w_rd_acc) && !fflush;

    // Next occupancy from the accepted access pair.
    always_comb begin
        w_cnt_nxt = r_count;
        if (w_wr_acc && !w_rd_acc) begin
            w_cnt_nxt = r_count + (AW+1)'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            w_cnt_nxt = r_count - (AW+1)'(1);
        end else begin
            w_cnt_nxt = r_count;
        end
    end

    assign w_flags_nxt = calc_flags(9'(w_cnt_nxt), 9'(upae), 9'(upaf), 9'(DEPTH));

    // Control state: async reset, flush as synchronous return to the reset state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_flags  <= FF_RESET;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_rvalid <= 1'b0;
        end else if (fflush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_flags  <= FF_RESET;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_rvalid <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count  <= w_cnt_nxt;
            r_flags  <= w_flags_nxt;
            r_ovf    <= r_ovf | (wen && w_full && !w_rd_acc);
            r_udf    <= r_udf | (ren && w_empty);
            r_rvalid <= w_rd_acc;
        end
    end

    assign wr_ptr = r_wr_ptr;
    assign rd_ptr = r_rd_ptr;
    assign wr_acc = w_wr_acc;
    assign rd_acc = w_rd_acc;
    assign count  = r_count;
    assign fflags = r_flags;
    assign ovf    = r_ovf;
    assign udf    = r_udf;
    assign rvalid = r_rvalid;

endmodule

// File: rtl/ql_fifo_sync.sv
// Register-based single-clock FIFO with the hard-RAM four-flag interface.
// Holds the storage array and the registered read-data path.
module ql_fifo_sync
    import ql_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    input  logic             fflush,
    input  logic [AW:0]      upae,
    input  logic [AW:0]      upaf,
    output logic [AW:0]      count,
    output logic [3:0]       fflags,
    output logic             ovf,
    output logic             udf
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;
    logic [AW-1:0]    w_wr_ptr;
    logic [AW-1:0]    w_rd_ptr;
    logic             w_wr_acc;
    logic             w_rd_acc;

    ql_fifo_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .wen    (wen),
        .ren    (ren),
        .fflush (fflush),
        .upae   (upae),
        .upaf   (upaf),
        .wr_ptr (w_wr_ptr),
        .rd_ptr (w_rd_ptr),
        .wr_acc (w_wr_acc),
        .rd_acc (w_rd_acc),
        .count  (count),
        .fflags (fflags),
        .ovf    (ovf),
        .udf    (udf),
        .rvalid (rvalid)
    );

    // Storage is deliberately not reset so it maps onto plain flops without reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_wr_ptr] <= wdata;
        end
    end

    // Read register; at full with a same-cycle write it still sees the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (w_rd_acc) begin
            r_rdata <= r_mem[w_rd_ptr];
        end
    end

    assign rdata = r_rdata;

endmodule
